// File: rtl/compress_rd_arb.sv
// Two-requester arbiter for a shared polynomial-memory read port with burst ownership
// and owner-tagged read-return pipe so returning data is flagged to the issuing requester.
module compress_rd_arb #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_zeroize,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_rd_en0,
   input  logic              i_rd_en1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_rd_addr,
   output logic              o_rd_valid0,
   output logic              o_rd_valid1,
   output logic              o_err_ungranted
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } arb_state_e;

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_last_owner;
   logic       w_clear;
   logic       w_owner;
   logic       w_illegal;
   logic       r_err;
   logic       r_vld_pipe [MEM_RD_LAT];
   logic       r_own_pipe [MEM_RD_LAT];

   assign w_clear = i_reset | i_zeroize;

   // State register; last_owner follows every entry into an ownership state.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_state      <= StIdle;
         r_last_owner <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == StOwn0) begin
            r_last_owner <= 1'b0;
         end else if (w_state_nxt == StOwn1) begin
            r_last_owner <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_req0 && i_req1) begin
               w_state_nxt = r_last_owner ? StOwn0 : StOwn1;
            end else if (i_req0) begin
               w_state_nxt = StOwn0;
            end else if (i_req1) begin
               w_state_nxt = StOwn1;
            end
         end
         StOwn0: begin
            if (!i_req0) begin
               w_state_nxt = i_req1 ? StOwn1 : StIdle;
            end
         end
         StOwn1: begin
            if (!i_req1) begin
               w_state_nxt = i_req0 ? StOwn0 : StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      o_gnt0        = (r_state == StOwn0);
      o_gnt1        = (r_state == StOwn1);
      w_owner       = (r_state == StOwn1);
      o_mem_rd_en   = (o_gnt0 & i_rd_en0) | (o_gnt1 & i_rd_en1);
      o_mem_rd_addr = '0;
      if (o_gnt0) begin
         o_mem_rd_addr = i_addr0;
      end else if (o_gnt1) begin
         o_mem_rd_addr = i_addr1;
      end
      w_illegal = (i_rd_en0 & ~o_gnt0) | (i_rd_en1 & ~o_gnt1);
   end

   // Tag pipe: each issued read carries its owner so handover cannot misroute returns.
   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         for (int i = 0; i < MEM_RD_LAT; i++) begin
            r_vld_pipe[i] <= 1'b0;
            r_own_pipe[i] <= 1'b0;
         end
         r_err <= 1'b0;
      end else begin
         r_vld_pipe[0] <= o_mem_rd_en;
         r_own_pipe[0] <= w_owner;
         for (int i = 1; i < MEM_RD_LAT; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_own_pipe[i] <= r_own_pipe[i-1];
         end
         r_err <= r_err | w_illegal;
      end
   end

   assign o_rd_valid0     = r_vld_pipe[MEM_RD_LAT-1] & ~r_own_pipe[MEM_RD_LAT-1];
   assign o_rd_valid1     = r_vld_pipe[MEM_RD_LAT-1] & r_own_pipe[MEM_RD_LAT-1];
   assign o_err_ungranted = r_err;

endmodule

// File: tb/tb_compress_rd_arb.sv
// Randomized and directed bench for compress_rd_arb against a queue-based reference model
// that tracks owner, round-robin history and due cycles of in-flight reads.
module tb_compress_rd_arb;

   localparam int unsigned AW  = 10;
   localparam int unsigned LAT = 3;

   logic          clk = 1'b0;
   logic          reset, zeroize, req0, req1, rd0, rd1;
   logic [AW-1:0] a0, a1;
   logic          gnt0, gnt1, mem_rd_en, rd_valid0, rd_valid1, err_ungranted;
   logic [AW-1:0] mem_rd_addr;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int m_own = -1;
   int m_last = 1;
   bit m_err = 1'b0;
   int q_due[$];
   int q_who[$];
   int cnt_v0, cnt_v1;

   always #5 clk = ~clk;

   compress_rd_arb #(
      .ADDR_W    (AW),
      .MEM_RD_LAT(LAT)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_zeroize      (zeroize),
      .i_req0         (req0),
      .i_req1         (req1),
      .i_rd_en0       (rd0),
      .i_rd_en1       (rd1),
      .i_addr0        (a0),
      .i_addr1        (a1),
      .o_gnt0         (gnt0),
      .o_gnt1         (gnt1),
      .o_mem_rd_en    (mem_rd_en),
      .o_mem_rd_addr  (mem_rd_addr),
      .o_rd_valid0    (rd_valid0),
      .o_rd_valid1    (rd_valid1),
      .o_err_ungranted(err_ungranted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit exp_valid(input int k);
      foreach (q_due[i]) begin
         if (q_due[i] == cyc && q_who[i] == k) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit exp_issue();
      return (m_own == 0 && rd0) || (m_own == 1 && rd1);
   endfunction

   task automatic compare();
      logic [AW-1:0] e_addr;
      e_addr = (m_own == 0) ? a0 : (m_own == 1) ? a1 : '0;
      check("gnt0", 32'(gnt0), 32'(m_own == 0));
      check("gnt1", 32'(gnt1), 32'(m_own == 1));
      check("mem_rd_en", 32'(mem_rd_en), 32'(exp_issue()));
      check("mem_rd_addr", 32'(mem_rd_addr), 32'(e_addr));
      check("rd_valid0", 32'(rd_valid0), 32'(exp_valid(0)));
      check("rd_valid1", 32'(rd_valid1), 32'(exp_valid(1)));
      check("err_ungranted", 32'(err_ungranted), 32'(m_err));
      cnt_v0 += int'(rd_valid0);
      cnt_v1 += int'(rd_valid1);
   endtask

   task automatic model_edge();
      int nxt;
      if (reset || zeroize) begin
         m_own  = -1;
         m_last = 1;
         m_err  = 1'b0;
         q_due.delete();
         q_who.delete();
      end else begin
         if (exp_issue()) begin
            q_due.push_back(cyc + LAT);
            q_who.push_back(m_own);
         end
         if ((rd0 && m_own != 0) || (rd1 && m_own != 1)) m_err = 1'b1;
         if (m_own == -1) begin
            if (req0 && req1) nxt = (m_last == 0) ? 1 : 0;
            else if (req0)    nxt = 0;
            else if (req1)    nxt = 1;
            else              nxt = -1;
         end else if (m_own == 0) begin
            nxt = req0 ? 0 : (req1 ? 1 : -1);
         end else begin
            nxt = req1 ? 1 : (req0 ? 0 : -1);
         end
         m_own = nxt;
         if (nxt >= 0) m_last = nxt;
      end
      cyc++;
      while (q_due.size() > 0 && q_due[0] < cyc) begin
         void'(q_due.pop_front());
         void'(q_who.pop_front());
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit r0, input bit r1, input bit e0, input bit e1,
                        input logic [AW-1:0] x0, input logic [AW-1:0] x1);
      req0 = r0; req1 = r1; rd0 = e0; rd1 = e1; a0 = x0; a1 = x1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, '0, '0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      zeroize = 1'b0;
      drive(0, 0, 0, 0, '0, '0);
      @(posedge clk);
      #1;
      do_reset();

      // Solo burst of 64 reads from 0x40
      drive(1, 0, 0, 0, '0, '0);
      cycle();
      check("solo_gnt0", 32'(gnt0), 32'd1);
      cnt_v0 = 0;
      cnt_v1 = 0;
      for (int i = 0; i < 64; i++) begin
         drive(1, 0, 1, 0, AW'('h40 + i), AW'($urandom));
         cycle();
      end
      drive(0, 0, 0, 0, '0, '0);
      repeat (LAT + 1) cycle();
      check("solo_v0_count", 32'(cnt_v0), 32'd64);
      check("solo_v1_count", 32'(cnt_v1), 32'd0);

      // Ties and round-robin
      do_reset();
      drive(1, 1, 0, 0, '0, '0);
      cycle();
      check("tie_gnt0", 32'(gnt0), 32'd1);
      drive(0, 1, 0, 0, '0, '0);
      cycle();
      check("handover_gnt1", 32'(gnt1), 32'd1);
      drive(0, 0, 0, 0, '0, '0);
      cycle();
      check("idle_gnt1", 32'(gnt1), 32'd0);
      drive(1, 1, 0, 0, '0, '0);
      cycle();
      check("tie2_gnt0", 32'(gnt0), 32'd1);
      drive(0, 0, 0, 0, '0, '0);
      cycle();
      drive(1, 1, 0, 0, '0, '0);
      cycle();
      check("tie3_gnt1", 32'(gnt1), 32'd1);

      // Handover with reads in flight
      do_reset();
      drive(1, 1, 0, 0, '0, '0);
      cycle();
      cnt_v0 = 0;
      cnt_v1 = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, AW'('h100 + i), '0);
         cycle();
      end
      drive(0, 1, 0, 0, '0, '0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 1, '0, AW'('h200 + i));
         cycle();
      end
      drive(0, 0, 0, 0, '0, '0);
      repeat (LAT + 1) cycle();
      check("ho_v0_count", 32'(cnt_v0), 32'd4);
      check("ho_v1_count", 32'(cnt_v1), 32'd4);

      // Illegal access by non-owner
      do_reset();
      drive(1, 0, 0, 0, '0, '0);
      cycle();
      drive(1, 0, 1, 1, AW'('h11), AW'('h22));
      cycle();
      drive(1, 0, 0, 0, '0, '0);
      repeat (3) cycle();
      check("illegal_err", 32'(err_ungranted), 32'd1);
      zeroize = 1'b1;
      cycle();
      zeroize = 1'b0;
      check("zeroize_err", 32'(err_ungranted), 32'd0);

      // Zeroize with reads pending, then fresh arbitration
      drive(1, 0, 0, 0, '0, '0);
      cycle();
      drive(1, 0, 1, 0, AW'('h33), '0);
      repeat (2) cycle();
      drive(1, 1, 0, 0, '0, '0);
      zeroize = 1'b1;
      cycle();
      zeroize = 1'b0;
      check("zero_gnt0", 32'(gnt0), 32'd0);
      cycle();
      check("zero_rearb_gnt0", 32'(gnt0), 32'd1);

      // Owner stall with other requester waiting
      repeat (10) cycle();
      check("stall_gnt1", 32'(gnt1), 32'd0);
      drive(0, 1, 0, 0, '0, '0);
      cycle();
      check("stall_release_gnt1", 32'(gnt1), 32'd1);

      // Randomized traffic
      drive(0, 0, 0, 0, '0, '0);
      for (int n = 0; n < 4000; n++) begin
         bit r0, r1, e0, e1;
         r0 = ($urandom_range(7) == 0) ? ~req0 : req0;
         r1 = ($urandom_range(7) == 0) ? ~req1 : req1;
         e0 = (m_own == 0) && r0 && ($urandom_range(2) != 0);
         e1 = (m_own == 1) && r1 && ($urandom_range(2) != 0);
         if ($urandom_range(63) == 0) e0 = 1'b1;
         if ($urandom_range(63) == 0) e1 = 1'b1;
         drive(r0, r1, e0, e1, AW'($urandom), AW'($urandom));
         reset   = ($urandom_range(199) == 0);
         zeroize = ($urandom_range(199) == 0);
         cycle();
      end
      reset   = 1'b0;
      zeroize = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
